spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//  SPI target (slave) endpoint: the far end of the SPI_rx master link. Samples SPI_sclk, SPI_csn and SPI_mosi in the clk domain.
//  - Shifts the next byte from a 1-entry TX holding buffer out on SPI_miso.
//  - Delivers every complete MOSI byte as a 1-cycle rx_valid pulse.
//  - Mode 0 only (CPOL=0, CPHA=0), MSB first; multi-byte bursts allowed within one CSN-low frame.
// PARAMETERS
//  DATA_W       8  bits per SPI word
//  SYNC_STAGES  2  flops per synchronizer on sclk/csn/mosi (min 2)
// PORTS
//  clk          in   1       system clock; f_sclk <= f_clk/8
//  rst          in   1       synchronous reset, active-high
//  tx_data      in   DATA_W  next byte to return on MISO
//  tx_valid     in   1       tx_data offered; accepted when tx_valid&tx_ready
//  tx_ready     out  1       TX holding buffer empty
//  tx_underrun  out  1       1-cycle pulse: word load found buffer empty, 0x00 sent
//  rx_data      out  DATA_W  last complete MOSI word, held until next
//  rx_valid     out  1       1-cycle pulse, rx_data updated same cycle
//  frame_err    out  1       1-cycle pulse: CSN rose with partial word (bit_cnt!=0)
//  busy         out  1       state==ACTIVE
//  SPI_sclk     in   1       async SPI clock from master
//  SPI_csn      in   1       async chip select, active-low
//  SPI_mosi     in   1       async master data
//  SPI_miso     out  1       target data (registered)
//  SPI_miso_oe  out  1       MISO drive enable = ~csn_sync
// BEHAVIOUR
//  Reset values
//  - tx_ready=1; rx_data=0; all pulses=0; busy=0; SPI_miso=0; SPI_miso_oe=0; bit_cnt=0; state=WAIT_HI.
//  FSM
//  - WAIT_HI -> IDLE on csn_sync==1. WAIT_HI is entered from reset, so a frame already in flight at reset release is ignored.
//  - IDLE -> ACTIVE on csn fall edge.
//  - ACTIVE -> IDLE on csn rise edge.
//  Edge detect: registered sync outputs; rise = s & ~s_d, fall = ~s & s_d. SCLK edges are ignored outside ACTIVE.
//  Word load (shifter <= word, SPI_miso <= word[MSB])
//  - Trigger 1: csn fall.
//  - Trigger 2: sclk fall with bit_cnt==0 while ACTIVE, i.e. after the 8th rise.
//  - Source: holding buffer if full, then buffer marked empty.
//  - Else tx_valid same cycle: bypass tx_data, accept it, buffer stays empty.
//  - Else 0x00, tx_underrun pulses.
//  sclk rise
//  - rx_sh <= {rx_sh[DATA_W-2:0], mosi_sync}; bit_cnt++.
//  - At bit_cnt==DATA_W-1: rx_data <= completed word, rx_valid=1, bit_cnt wraps to 0.
//  sclk fall with bit_cnt!=0: shifter <<= 1; SPI_miso <= next bit.
//  Latency: rx_valid 1 cycle after the detected sclk rise (SYNC_STAGES+2 clk after the pad edge).
//  csn rise: bit_cnt=0, partial rx bits discarded, no rx_valid. frame_err if bit_cnt!=0. The unsent shifter byte is dropped; the buffer is kept.
//  Simultaneous events
//  - csn rise and sclk rise same cycle: csn wins, edge ignored.
//  - tx_valid while buffer full: not accepted (tx_ready=0).
//  - Accept and load same cycle with full buffer: load old, store new.
//  Reset mid-frame: all state cleared, MISO tri-stated; new frame begins only after CSN high seen.
// STRUCTURE
//  spi_pkg: DATA_W default; state enum {WAIT_HI, IDLE, ACTIVE}; SPI_MODE0 constants (CPOL=0, CPHA=0).
//  Sub-module spi_sync_edge: SYNC_STAGES synchronizer + registered rise/fall detect; instanced x3 (sclk, csn, mosi; mosi uses level only).
//  Top: FSM, bit counter, rx/tx shifters, TX holding buffer.
// TESTING (bench master, sclk = clk/8, mode 0)
//  1. Preload 0xA5, frame MOSI 0x3C -> MISO bits 1,0,1,0,0,1,0,1; one rx_valid with rx_data=0x3C; tx_ready back to 1.
//  2. Burst 0x11,0x22 with 0xC3 buffered and 0x5A pushed mid-word -> MISO 0xC3 then 0x5A; two rx_valid (0x11, 0x22); no underrun.
//  3. Empty buffer at CSN fall -> MISO 0x00, tx_underrun 1 pulse; tx_valid same cycle as load -> bypass byte sent, no underrun.
//  4. CSN raised after 5 bits -> frame_err pulse, no rx_valid; next frame 0xF0 received intact.
//  5. rst asserted mid-word -> outputs reach reset values next cycle; CSN still low -> no activity until CSN high then low.
//  6. SCLK toggling with CSN high -> no rx_valid, SPI_miso_oe=0, state stays IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI target endpoint.
package spi_pkg;

    localparam int DEF_DATA_W = 8;

    // Only SPI mode 0 is supported: SCLK idles low, data sampled on the rising edge.
    localparam bit SPI_MODE0_CPOL = 1'b0;
    localparam bit SPI_MODE0_CPHA = 1'b0;

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        IDLE    = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

endpackage

// File: rtl/spi_slave_if_if.sv
// Parallel-side handshake bundle of the SPI target: TX holding buffer in, RX words out.
interface spi_slave_if_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_underrun;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_underrun, rx_data, rx_valid, frame_err, busy
    );

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_underrun, rx_data, rx_valid, frame_err, busy
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pad plus registered edge detection.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   lvl_p1;
    logic                   rise_p1;
    logic                   fall_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            lvl_p1  <= 1'b0;
            rise_p1 <= 1'b0;
            fall_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
            // ---- stage p1: level and its edges stay cycle-aligned ----
            lvl_p1  <= sync_p0[SYNC_STAGES-1];
            rise_p1 <= sync_p0[SYNC_STAGES-1] & ~lvl_p1;
            fall_p1 <= ~sync_p0[SYNC_STAGES-1] & lvl_p1;
        end
    end

    assign level = lvl_p1;
    assign rise  = rise_p1;
    assign fall  = fall_p1;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 target: synchronized pads, frame FSM, RX/TX shifters and a 1-entry TX holding buffer.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    spi_slave_if_if.slave      bus,
    input  logic               SPI_sclk,
    input  logic               SPI_csn,
    input  logic               SPI_mosi,
    output logic               SPI_miso,
    output logic               SPI_miso_oe
);

    localparam int CNT_W = $clog2(DATA_W);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic csn_lvl, csn_rise, csn_fall;
    logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst(rst), .raw(SPI_sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_csn (
        .clk(clk), .rst(rst), .raw(SPI_csn),
        .level(csn_lvl), .rise(csn_rise), .fall(csn_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
        .clk(clk), .rst(rst), .raw(SPI_mosi),
        .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-2:0]   rx_sh;
    logic [DATA_W-2:0]   tx_sh;
    logic [DATA_W-1:0]   buf_data;
    logic                buf_full;
    logic [DATA_W-1:0]   rx_data;
    logic                rx_valid;
    logic                tx_underrun;
    logic                frame_err;
    logic                miso;
    logic                miso_oe;

    logic                in_frame;
    logic                load_evt;
    logic                tx_ready;
    logic                bypass;
    logic                store;
    logic                empty_load;
    logic [DATA_W-1:0]   load_word;

    // A CSN rise in the same cycle as an SCLK edge ends the frame; the edge is ignored.
    assign in_frame = (state == ACTIVE) && !csn_rise;
    assign load_evt = ((state == IDLE) && csn_fall)
                    || (in_frame && sclk_fall && (bit_cnt == '0));
    // The buffer slot frees up in the same cycle a load drains it.
    assign tx_ready = ~buf_full | load_evt;
    assign bypass   = load_evt & ~buf_full & bus.tx_valid;
    assign store    = bus.tx_valid & tx_ready & ~bypass;

    always_comb begin
        load_word  = '0;
        empty_load = 1'b0;
        if (buf_full) begin
            load_word = buf_data;
        end else if (bus.tx_valid) begin
            load_word = bus.tx_data;
        end else begin
            empty_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_HI;
            bit_cnt     <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            // MISO stays tri-stated until a clean CSN-high has been seen after reset.
            miso_oe     <= ~csn_lvl && (state != WAIT_HI);

            if (store) begin
                buf_data <= bus.tx_data;
                buf_full <= 1'b1;
            end else if (load_evt && buf_full) begin
                buf_full <= 1'b0;
            end

            if (load_evt) begin
                tx_sh       <= load_word[DATA_W-2:0];
                miso        <= load_word[DATA_W-1];
                tx_underrun <= empty_load;
            end else if (in_frame && sclk_fall) begin
                tx_sh <= {tx_sh[DATA_W-3:0], 1'b0};
                miso  <= tx_sh[DATA_W-2];
            end

            case (state)
                WAIT_HI: begin
                    if (csn_lvl) state <= IDLE;
                end
                IDLE: begin
                    if (csn_fall) begin
                        state   <= ACTIVE;
                        bit_cnt <= '0;
                    end
                end
                ACTIVE: begin
                    if (csn_rise) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        frame_err <= (bit_cnt != '0);
                    end else if (sclk_rise) begin
                        rx_sh <= {rx_sh[DATA_W-3:0], mosi_lvl};
                        if (bit_cnt == CNT_W'(DATA_W-1)) begin
                            rx_data  <= {rx_sh, mosi_lvl};
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= WAIT_HI;
            endcase
        end
    end

    assign bus.tx_ready    = tx_ready;
    assign bus.tx_underrun = tx_underrun;
    assign bus.rx_data     = rx_data;
    assign bus.rx_valid    = rx_valid;
    assign bus.frame_err   = frame_err;
    assign bus.busy        = (state == ACTIVE);
    assign SPI_miso        = miso;
    assign SPI_miso_oe     = miso_oe;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a mode-0 bus master at clk/8 plus pulse monitors.
module tb_spi_slave_if;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic csn = 1'b1;
    logic mosi = 1'b0;
    logic miso;
    logic miso_oe;

    int n_cmp = 0;
    int n_err = 0;

    int rx_cnt = 0;
    int ur_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] rx_hist [0:63];

    spi_slave_if_if #(.DATA_W(8)) bus ();

    spi_slave_if #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .SPI_sclk(sclk), .SPI_csn(csn), .SPI_mosi(mosi),
        .SPI_miso(miso), .SPI_miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    // Pulses last one clk cycle, so the falling edge sees each exactly once.
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_hist[rx_cnt % 64] = bus.rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (bus.tx_underrun) ur_cnt = ur_cnt + 1;
        if (bus.frame_err) fe_cnt = fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        while (!bus.tx_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (!bus.tx_ready) check("push_timeout", 32'd0, 32'd1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
    endtask

    // Bit j of the frame is mosi_bits[nbits-1-j]; MISO is sampled just before each rise.
    task automatic spi_frame(input logic [15:0] mosi_bits, input int nbits,
                             output logic [15:0] miso_bits);
        miso_bits = '0;
        csn = 1'b0;
        for (int j = 0; j < nbits; j++) begin
            mosi = mosi_bits[nbits-1-j];
            tick(4);
            miso_bits = {miso_bits[14:0], miso};
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
        tick(4);
        csn = 1'b1;
        tick(8);
    endtask

    logic [15:0] got;
    int rx0, ur0, fe0;

    initial begin
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        tick(3);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_rx_data", 32'(bus.rx_data), 32'h00);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_pulses", 32'({bus.rx_valid, bus.tx_underrun, bus.frame_err}), 32'd0);
        rst = 1'b0;
        tick(8);

        // 1: preloaded 0xA5 out, 0x3C in
        push(8'hA5);
        check("t1_ready_full", 32'(bus.tx_ready), 32'd0);
        rx0 = rx_cnt;
        spi_frame(16'h003C, 8, got);
        check("t1_miso", 32'(got[7:0]), 32'hA5);
        check("t1_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
        check("t1_rx_data", 32'(bus.rx_data), 32'h3C);
        check("t1_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("t1_miso_oe_off", 32'(miso_oe), 32'd0);

        // 2: two-word burst, second TX byte pushed mid-word, filler keeps the tail load fed
        push(8'hC3);
        rx0 = rx_cnt;
        ur0 = ur_cnt;
        fork
            spi_frame(16'h1122, 16, got);
            begin
                tick(20);
                push(8'h5A);
                tick(70);
                push(8'hEE);
            end
        join
        check("t2_miso", 32'(got), 32'hC35A);
        check("t2_rx_cnt", 32'(rx_cnt - rx0), 32'd2);
        check("t2_rx_w0", 32'(rx_hist[rx0 % 64]), 32'h11);
        check("t2_rx_w1", 32'(rx_hist[(rx0 + 1) % 64]), 32'h22);
        check("t2_underrun", 32'(ur_cnt - ur0), 32'd0);

        // 3a: empty buffer at CSN fall sends 0x00 and flags one underrun
        ur0 = ur_cnt;
        fork
            spi_frame(16'h0055, 8, got);
            begin
                tick(30);
                push(8'hEE);
            end
        join
        check("t3_miso_zero", 32'(got[7:0]), 32'h00);
        check("t3_underrun", 32'(ur_cnt - ur0), 32'd1);

        // 3b: tx_valid exactly on the CSN-fall load cycle is bypassed straight out
        ur0 = ur_cnt;
        fork
            spi_frame(16'h0066, 8, got);
            begin
                tick(3);
                bus.tx_data  = 8'h96;
                bus.tx_valid = 1'b1;
                tick(1);
                bus.tx_valid = 1'b0;
                check("t3_bypass_ready", 32'(bus.tx_ready), 32'd1);
                tick(30);
                push(8'hEE);
            end
        join
        check("t3_miso_bypass", 32'(got[7:0]), 32'h96);
        check("t3_no_underrun", 32'(ur_cnt - ur0), 32'd0);
        check("t3_rx_data", 32'(bus.rx_data), 32'h66);

        // 4: CSN rises after 5 bits, then a clean frame
        rx0 = rx_cnt;
        fe0 = fe_cnt;
        spi_frame(16'h0015, 5, got);
        check("t4_frame_err", 32'(fe_cnt - fe0), 32'd1);
        check("t4_no_rx", 32'(rx_cnt - rx0), 32'd0);
        spi_frame(16'h00F0, 8, got);
        check("t4_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
        check("t4_rx_data", 32'(bus.rx_data), 32'hF0);
        check("t4_frame_err_once", 32'(fe_cnt - fe0), 32'd1);

        // 5: reset mid-word while CSN stays low
        push(8'hFF);
        csn = 1'b0;
        tick(8);
        push(8'h77);
        for (int j = 0; j < 3; j++) begin
            mosi = j[0];
            tick(4);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
        check("t5_pre_busy", 32'(bus.busy), 32'd1);
        check("t5_pre_miso", 32'(miso), 32'd1);
        check("t5_pre_ready", 32'(bus.tx_ready), 32'd0);
        rst = 1'b1;
        tick(1);
        check("t5_rst_ready", 32'(bus.tx_ready), 32'd1);
        check("t5_rst_rx_data", 32'(bus.rx_data), 32'h00);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_miso", 32'({miso, miso_oe}), 32'd0);
        rst = 1'b0;
        rx0 = rx_cnt;
        for (int j = 0; j < 10; j++) begin
            tick(4);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
        check("t5_idle_rx", 32'(rx_cnt - rx0), 32'd0);
        check("t5_idle_busy", 32'(bus.busy), 32'd0);
        check("t5_idle_oe", 32'(miso_oe), 32'd0);
        csn = 1'b1;
        tick(10);
        push(8'h3C);
        spi_frame(16'h0081, 8, got);
        check("t5_new_miso", 32'(got[7:0]), 32'h3C);
        check("t5_new_rx", 32'(bus.rx_data), 32'h81);
        check("t5_new_rx_cnt", 32'(rx_cnt - rx0), 32'd1);

        // 6: SCLK activity with CSN high is ignored
        rx0 = rx_cnt;
        for (int j = 0; j < 8; j++) begin
            mosi = ~mosi;
            tick(4);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
            if (j == 4) check("t6_oe_mid", 32'(miso_oe), 32'd0);
        end
        tick(6);
        check("t6_no_rx", 32'(rx_cnt - rx0), 32'd0);
        check("t6_oe", 32'(miso_oe), 32'd0);
        check("t6_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
